// File: rtl/lcd_ctrl_param_if.sv
// Host-side bus of the LCD window controller: command strobe, load data and window stream.
interface lcd_ctrl_param_if #(
  parameter int DW = 8
) ();
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  modport master (
    output cmd, cmd_valid, datain,
    input  dataout, output_valid, busy
  );

  modport slave (
    input  cmd, cmd_valid, datain,
    output dataout, output_valid, busy
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD window controller: stores an IMG_W x IMG_H image and streams a
// WIN_W x WIN_H window after every command, with shift, mirror and recentre support.
module lcd_ctrl_param #(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int WIN_W = 3,
  parameter int WIN_H = 3,
  parameter int WRAP  = 0
) (
  input logic              clk,
  input logic              reset,
  lcd_ctrl_param_if.slave  bus
);

  localparam int P    = IMG_W * IMG_H;
  localparam int N    = WIN_W * WIN_H;
  localparam int PW   = (P > 1) ? $clog2(P) : 1;
  localparam int NW   = (N > 1) ? $clog2(N) : 1;
  localparam int XMAX = IMG_W - WIN_W;
  localparam int YMAX = IMG_H - WIN_H;
  localparam int XW   = (XMAX > 0) ? $clog2(XMAX + 1) : 1;
  localparam int YW   = (YMAX > 0) ? $clog2(YMAX + 1) : 1;
  localparam int RW   = (WIN_H > 1) ? $clog2(WIN_H) : 1;
  localparam int CW   = (WIN_W > 1) ? $clog2(WIN_W) : 1;

  localparam logic [XW-1:0] X_MAX = XW'(XMAX);
  localparam logic [YW-1:0] Y_MAX = YW'(YMAX);
  localparam logic [XW-1:0] X0    = XW'(XMAX / 2);
  localparam logic [YW-1:0] Y0    = YW'(YMAX / 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_t;
  typedef enum logic [2:0] {
    C_REFLASH, C_LOAD, C_RIGHT, C_LEFT, C_UP, C_DOWN, C_MIRROR, C_RECENTRE
  } cmd_t;

  state_t        state;
  logic          busy_q;
  logic          ov_q;
  logic [DW-1:0] dout_q;
  logic          mirror;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [PW-1:0] ld_cnt;
  logic [NW-1:0] out_cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] mem [P];

  logic [CW-1:0] col_eff;
  logic [31:0]   addr_full;
  logic [PW-1:0] rd_addr;
  logic [XW-1:0] x_inc, x_dec;
  logic [YW-1:0] y_inc, y_dec;

  always_comb begin
    col_eff   = mirror ? (CW'(WIN_W - 1) - col) : col;
    addr_full = (32'(y) + 32'(row)) * 32'(IMG_W) + 32'(x) + 32'(col_eff);
    rd_addr   = addr_full[PW-1:0];
    // At a bound the origin either holds (saturate) or jumps to the opposite bound.
    x_inc = (x == X_MAX) ? ((WRAP != 0) ? '0    : x) : x + 1'b1;
    x_dec = (x == '0)    ? ((WRAP != 0) ? X_MAX : x) : x - 1'b1;
    y_inc = (y == Y_MAX) ? ((WRAP != 0) ? '0    : y) : y + 1'b1;
    y_dec = (y == '0)    ? ((WRAP != 0) ? Y_MAX : y) : y - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      dout_q  <= '0;
      mirror  <= 1'b0;
      x       <= X0;
      y       <= Y0;
      ld_cnt  <= '0;
      out_cnt <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // busy stays high for one IDLE cycle after the last word so it falls with output_valid.
          if (busy_q) begin
            busy_q <= 1'b0;
            ov_q   <= 1'b0;
          end else if (bus.cmd_valid) begin
            busy_q  <= 1'b1;
            ld_cnt  <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
            state   <= S_OUT;
            case (cmd_t'(bus.cmd))
              C_LOAD:     state  <= S_LOAD;
              C_RIGHT:    x      <= x_inc;
              C_LEFT:     x      <= x_dec;
              C_UP:       y      <= y_dec;
              C_DOWN:     y      <= y_inc;
              C_MIRROR:   mirror <= ~mirror;
              C_RECENTRE: begin
                x <= X0;
                y <= Y0;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (ld_cnt == PW'(P - 1)) begin
            state  <= S_OUT;
            x      <= X0;
            y      <= Y0;
            mirror <= 1'b0;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        S_OUT: begin
          dout_q <= mem[rd_addr];
          ov_q   <= 1'b1;
          if (out_cnt == NW'(N - 1)) begin
            state <= S_IDLE;
          end else begin
            out_cnt <= out_cnt + 1'b1;
            if (col == CW'(WIN_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Image memory has no reset so its contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (reset && state == S_LOAD) mem[ld_cnt] <= bus.datain;
  end

  assign bus.dataout      = dout_q;
  assign bus.output_valid = ov_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: a saturating and a wrapping instance share one
// command stream; a reference model queues expected window words for each.
module tb_lcd_ctrl_param;

  localparam int IW = 8;
  localparam int IH = 8;
  localparam int WW = 3;
  localparam int WH = 3;
  localparam int P  = IW * IH;
  localparam int XM = IW - WW;
  localparam int YM = IH - WH;
  localparam int XC = XM / 2;
  localparam int YC = YM / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [7:0] datain = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [P];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int mx [2];
  int my [2];
  int mir [2];
  int wr [2] = '{0, 1};

  always #5 clk = ~clk;

  lcd_ctrl_param_if #(.DW(8)) b0 ();
  lcd_ctrl_param_if #(.DW(8)) b1 ();

  assign b0.cmd = cmd;
  assign b0.cmd_valid = cmd_valid;
  assign b0.datain = datain;
  assign b1.cmd = cmd;
  assign b1.cmd_valid = cmd_valid;
  assign b1.datain = datain;

  lcd_ctrl_param #(.DW(8), .IMG_W(IW), .IMG_H(IH), .WIN_W(WW), .WIN_H(WH), .WRAP(0))
    u_sat (.clk(clk), .reset(reset), .bus(b0));
  lcd_ctrl_param #(.DW(8), .IMG_W(IW), .IMG_H(IH), .WIN_W(WW), .WIN_H(WH), .WRAP(1))
    u_wrap (.clk(clk), .reset(reset), .bus(b1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b0.output_valid) begin
      if (q0.size() == 0) check("extra_out_sat", 32'(q0.size()), 32'd1);
      else check("dout_sat", 32'(b0.dataout), 32'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (b1.output_valid) begin
      if (q1.size() == 0) check("extra_out_wrap", 32'(q1.size()), 32'd1);
      else check("dout_wrap", 32'(b1.dataout), 32'(q1.pop_front()));
    end
  end

  task automatic model_cmd(input int d, input logic [2:0] c);
    int cc;
    case (c)
      3'd1, 3'd7: begin mx[d] = XC; my[d] = YC; if (c == 3'd1) mir[d] = 0; end
      3'd2: mx[d] = (mx[d] == XM) ? (wr[d] != 0 ? 0 : XM) : mx[d] + 1;
      3'd3: mx[d] = (mx[d] == 0) ? (wr[d] != 0 ? XM : 0) : mx[d] - 1;
      3'd4: my[d] = (my[d] == 0) ? (wr[d] != 0 ? YM : 0) : my[d] - 1;
      3'd5: my[d] = (my[d] == YM) ? (wr[d] != 0 ? 0 : YM) : my[d] + 1;
      3'd6: mir[d] = 1 - mir[d];
      default: ;
    endcase
    for (int r = 0; r < WH; r++)
      for (int c2 = 0; c2 < WW; c2++) begin
        cc = (mir[d] != 0) ? (WW - 1 - c2) : c2;
        if (d == 0) q0.push_back(img[(my[d] + r) * IW + mx[d] + cc]);
        else        q1.push_back(img[(my[d] + r) * IW + mx[d] + cc]);
      end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin mx[d] = XC; my[d] = YC; mir[d] = 0; end
    q0.delete();
    q1.delete();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!b0.busy && !b1.busy) break;
    end
    check("idle_timeout", 32'(k < 200), 32'd1);
    check("drained_sat", 32'(q0.size()), 32'd0);
    check("drained_wrap", 32'(q1.size()), 32'd0);
  endtask

  // Issues one command; for LOAD feeds nfeed pixels of the ramp XORed with mask.
  task automatic do_cmd(input logic [2:0] c, input int nfeed, input logic [7:0] mask);
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("busy_set", 32'({b0.busy, b1.busy}), 32'd3);
    model_cmd(0, c);
    model_cmd(1, c);
    if (c == 3'd1) begin
      datain = img[0] ^ mask;
      for (int i = 1; i < nfeed; i++) begin
        @(posedge clk);
        #1;
        datain = img[i] ^ mask;
      end
    end
  endtask

  initial begin
    int k;
    int n;
    for (int i = 0; i < P; i++) img[i] = 8'(i);
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_busy", 32'({b0.busy, b1.busy}), 32'd0);
    check("rst_ov", 32'({b0.output_valid, b1.output_valid}), 32'd0);
    check("rst_dout", 32'(b0.dataout), 32'd0);
    reset = 1'b1;

    // Case 1: LOAD ramp, stream length and busy release timing
    do_cmd(3'd1, P, 8'h00);
    k = 0;
    while (!b0.output_valid && k < 200) begin @(negedge clk); k++; end
    check("stream_start", 32'(k < 200), 32'd1);
    n = 0;
    while (b0.output_valid && n < 50) begin n++; @(negedge clk); end
    check("stream_len", 32'(n), 32'd9);
    check("busy_fall", 32'({b0.busy, b1.busy}), 32'd0);
    check("ov_fall", 32'({b0.output_valid, b1.output_valid}), 32'd0);
    check("dout_hold", 32'(b0.dataout), 32'd36);
    wait_idle();

    // Cases 2/3: RIGHT x4, then LEFT
    for (int i = 0; i < 4; i++) begin do_cmd(3'd2, 0, 8'h00); wait_idle(); end
    check("sat_right_last", 32'(b0.dataout), 32'd39);
    check("wrap_right_last", 32'(b1.dataout), 32'd34);
    do_cmd(3'd3, 0, 8'h00);
    wait_idle();
    check("wrap_left_last", 32'(b1.dataout), 32'd39);

    // Vertical edges
    do_cmd(3'd7, 0, 8'h00); wait_idle();
    for (int i = 0; i < 3; i++) begin do_cmd(3'd4, 0, 8'h00); wait_idle(); end
    do_cmd(3'd5, 0, 8'h00); wait_idle();
    do_cmd(3'd5, 0, 8'h00); wait_idle();

    // Case 4: mirror toggling, then LOAD clears mirror
    do_cmd(3'd7, 0, 8'h00); wait_idle();
    do_cmd(3'd6, 0, 8'h00); wait_idle();
    check("mirror_last", 32'(b0.dataout), 32'd34);
    do_cmd(3'd6, 0, 8'h00); wait_idle();
    do_cmd(3'd6, 0, 8'h00); wait_idle();
    do_cmd(3'd1, P, 8'h00); wait_idle();

    // Case 5: RIGHT held during busy is ignored
    do_cmd(3'd0, 0, 8'h00);
    cmd = 3'd2;
    cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    do_cmd(3'd0, 0, 8'h00); wait_idle();
    do_cmd(3'd3, 0, 8'h00); wait_idle();
    do_cmd(3'd7, 0, 8'h00); wait_idle();
    check("recentre_last", 32'(b0.dataout), 32'd36);

    // Reset while idle keeps the image
    do_cmd(3'd2, 0, 8'h00); wait_idle();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    do_cmd(3'd0, 0, 8'h00); wait_idle();

    // Case 6: reset during LOAD aborts, fresh LOAD recovers
    do_cmd(3'd1, 30, 8'h80);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_busy", 32'({b0.busy, b1.busy}), 32'd0);
    check("abort_ov", 32'({b0.output_valid, b1.output_valid}), 32'd0);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_quiet", 32'({b0.busy, b1.busy}), 32'd0);
    do_cmd(3'd1, P, 8'h00); wait_idle();
    check("reload_last", 32'(b0.dataout), 32'd36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
